// File: rtl/vw_elem_unpack_if.sv
// Handshake bus for the element unpacker: packed-word input side and
// per-element output side. The producer/consumer pair uses the master view.
interface vw_elem_unpack_if #(
    parameter int XLEN      = 32,
    parameter int MAX_WIDEN = 4
);
    localparam int IDXW = $clog2(XLEN / 8);

    logic                        in_valid;
    logic                        in_ready;
    logic [XLEN-1:0]             in_a;
    logic [XLEN-1:0]             in_b;
    logic [XLEN*MAX_WIDEN-1:0]   in_c;
    logic [1:0]                  in_vsew;
    logic [1:0]                  in_widening;
    logic                        in_signed;

    logic                        out_valid;
    logic                        out_ready;
    logic [XLEN-1:0]             out_a;
    logic [XLEN-1:0]             out_b;
    logic [XLEN-1:0]             out_c;
    logic [IDXW-1:0]             out_idx;
    logic                        out_last;
    logic                        err_illegal;

    modport master (
        output in_valid, in_a, in_b, in_c, in_vsew, in_widening, in_signed,
        output out_ready,
        input  in_ready,
        input  out_valid, out_a, out_b, out_c, out_idx, out_last, err_illegal
    );

    modport slave (
        input  in_valid, in_a, in_b, in_c, in_vsew, in_widening, in_signed,
        input  out_ready,
        output in_ready,
        output out_valid, out_a, out_b, out_c, out_idx, out_last, err_illegal
    );
endinterface

// File: rtl/vw_elem_unpack.sv
// Sequential unpacker: splits one packed a/b/c word into SEW-sized elements,
// one per cycle, sign/zero-extending a and b to XLEN and c from SEW*W.
module vw_elem_unpack #(
    parameter int XLEN      = 32,
    parameter int MAX_WIDEN = 4
) (
    input  logic             clk,
    input  logic             n_reset,
    vw_elem_unpack_if.slave  bus
);
    localparam int IDXW = $clog2(XLEN / 8);
    localparam int CWID = XLEN * MAX_WIDEN;
    localparam int NK   = IDXW + 1;
    localparam int KW   = (NK > 1) ? $clog2(NK) : 1;
    localparam logic [IDXW-1:0] IDX_ONE = IDXW'(1);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t            state_q;
    logic [XLEN-1:0]   a_q;
    logic [XLEN-1:0]   b_q;
    logic [CWID-1:0]   c_q;
    logic [1:0]        vsew_q;
    logic [1:0]        wid_q;
    logic              sgn_q;

    logic              out_valid_q;
    logic [XLEN-1:0]   out_a_q;
    logic [XLEN-1:0]   out_b_q;
    logic [XLEN-1:0]   out_c_q;
    logic [IDXW-1:0]   idx_q;
    logic              last_q;
    logic              err_q;

    logic              out_fire;
    logic              in_ready;
    logic              accept;
    logic              illegal_in;
    int                in_sew;
    int                in_w;

    logic [XLEN-1:0]   src_a;
    logic [XLEN-1:0]   src_b;
    logic [CWID-1:0]   src_c;
    logic [1:0]        src_vsew;
    logic [1:0]        src_wid;
    logic              src_sgn;
    logic [IDXW-1:0]   idx_d;
    logic              last_d;
    int                k_a;
    int                k_c;
    logic [KW-1:0]     k_a_sel;
    logic [KW-1:0]     k_c_sel;
    logic [XLEN-1:0]   sh_a;
    logic [XLEN-1:0]   sh_b;
    logic [XLEN-1:0]   sh_c;

    logic [XLEN-1:0]   ext_a [NK];
    logic [XLEN-1:0]   ext_b [NK];
    logic [XLEN-1:0]   ext_c [NK];
    logic [XLEN-1:0]   out_a_d;
    logic [XLEN-1:0]   out_b_d;
    logic [XLEN-1:0]   out_c_d;

    // Handshake: a new word is taken while idle, or in the same cycle the
    // last element of the current word is consumed (no bubble).
    assign out_fire = out_valid_q & bus.out_ready;
    assign in_ready = (state_q == IDLE) | (out_fire & last_q);
    assign accept   = bus.in_valid & in_ready;

    always_comb begin
        in_sew     = 8 << bus.in_vsew;
        in_w       = 1 << bus.in_widening;
        illegal_in = (bus.in_vsew == 2'd3) | (bus.in_widening == 2'd3) |
                     (in_sew * in_w > XLEN) | (in_w > MAX_WIDEN);
    end

    // Element source is the incoming word on accept, else the latched copy.
    always_comb begin
        src_a    = accept ? bus.in_a        : a_q;
        src_b    = accept ? bus.in_b        : b_q;
        src_c    = accept ? bus.in_c        : c_q;
        src_vsew = accept ? bus.in_vsew     : vsew_q;
        src_wid  = accept ? bus.in_widening : wid_q;
        src_sgn  = accept ? bus.in_signed   : sgn_q;
        idx_d    = accept ? '0 : (idx_q + IDX_ONE);

        // k is log2(width/8); clamping only matters for illegal configs,
        // whose outputs are never presented.
        k_a = int'(src_vsew);
        k_c = int'(src_vsew) + int'(src_wid);
        if (k_a > NK - 1) k_a = NK - 1;
        if (k_c > NK - 1) k_c = NK - 1;
        k_a_sel = KW'(k_a);
        k_c_sel = KW'(k_c);

        sh_a   = src_a >> (int'(idx_d) << (3 + k_a));
        sh_b   = src_b >> (int'(idx_d) << (3 + k_a));
        sh_c   = XLEN'(src_c >> (int'(idx_d) << (3 + k_c)));
        last_d = (int'(idx_d) == ((XLEN / 8) >> k_a) - 1);
    end

    // One extender per supported element width; full-width is a pass-through.
    genvar gi;
    generate
        for (gi = 0; gi < NK; gi++) begin : g_ext
            localparam int EW = 8 << gi;
            if (EW >= XLEN) begin : g_full
                assign ext_a[gi] = sh_a;
                assign ext_b[gi] = sh_b;
                assign ext_c[gi] = sh_c;
            end else begin : g_part
                assign ext_a[gi] = {{(XLEN-EW){src_sgn & sh_a[EW-1]}}, sh_a[EW-1:0]};
                assign ext_b[gi] = {{(XLEN-EW){src_sgn & sh_b[EW-1]}}, sh_b[EW-1:0]};
                assign ext_c[gi] = {{(XLEN-EW){src_sgn & sh_c[EW-1]}}, sh_c[EW-1:0]};
            end
        end
    endgenerate

    assign out_a_d = ext_a[k_a_sel];
    assign out_b_d = ext_b[k_a_sel];
    assign out_c_d = ext_c[k_c_sel];

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            vsew_q      <= '0;
            wid_q       <= '0;
            sgn_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_c_q     <= '0;
            idx_q       <= '0;
            last_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            err_q <= accept & illegal_in;
            if (accept) begin
                a_q    <= bus.in_a;
                b_q    <= bus.in_b;
                c_q    <= bus.in_c;
                vsew_q <= bus.in_vsew;
                wid_q  <= bus.in_widening;
                sgn_q  <= bus.in_signed;
                if (illegal_in) begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    idx_q       <= '0;
                    last_q      <= 1'b0;
                end else begin
                    state_q     <= EMIT;
                    out_valid_q <= 1'b1;
                    out_a_q     <= out_a_d;
                    out_b_q     <= out_b_d;
                    out_c_q     <= out_c_d;
                    idx_q       <= idx_d;
                    last_q      <= last_d;
                end
            end else if (out_fire) begin
                if (last_q) begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    idx_q       <= '0;
                    last_q      <= 1'b0;
                end else begin
                    out_a_q <= out_a_d;
                    out_b_q <= out_b_d;
                    out_c_q <= out_c_d;
                    idx_q   <= idx_d;
                    last_q  <= last_d;
                end
            end
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_a       = out_a_q;
    assign bus.out_b       = out_b_q;
    assign bus.out_c       = out_c_q;
    assign bus.out_idx     = idx_q;
    assign bus.out_last    = last_q;
    assign bus.err_illegal = err_q;
endmodule
